// File: rtl/blackbox_check_pkg.sv
// Shared types and sizing constants for the serial blackbox value checker.
// Counter widths are sized for the largest legal WIDTH, LATENCY and REPEAT.
package blackbox_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        DONE
    } state_t;

    localparam int MISMATCH_W = 16;
    localparam logic [MISMATCH_W-1:0] MISMATCH_SAT = '1;

    localparam int BIT_IDX_W  = 6;
    localparam int WORD_IDX_W = 16;
    localparam int DLY_W      = 8;

endpackage

// File: rtl/blackbox_value_checker_if.sv
// Control and result bundle between a checker and its harness.
// The master side drives start and the serial stream; the slave reports results.
interface blackbox_value_checker_if
    import blackbox_check_pkg::*;
#(
    parameter int unsigned WIDTH = 1
);
    logic                  start;
    logic                  in;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [MISMATCH_W-1:0] mismatches;
    logic [WIDTH-1:0]      word;

    modport master (
        output start, in,
        input  busy, done, pass, mismatches, word
    );

    modport slave (
        input  start, in,
        output busy, done, pass, mismatches, word
    );
endinterface

// File: rtl/blackbox_shift_capture.sv
// LSB-first serial-to-parallel capture with bit index and word-complete strobe.
// Latency: completed word is presented alongside its final bit; no backpressure, one bit per sample cycle.
module blackbox_shift_capture
    import blackbox_check_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample,
    input  logic                 in,
    output logic [BIT_IDX_W-1:0] bit_idx,
    output logic                 word_done,
    output logic [WIDTH-1:0]     assembled
);
    logic [WIDTH-1:0] shreg;
    logic             last;

    assign last      = (bit_idx == BIT_IDX_W'(WIDTH - 1));
    assign word_done = sample && last;

    // Current bit merged in so the full word is ready on the wrapping sample.
    always_comb begin
        assembled = shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_idx == BIT_IDX_W'(i)) assembled[i] = in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (sample) begin
            shreg   <= assembled;
            bit_idx <= last ? '0 : bit_idx + BIT_IDX_W'(1);
        end
    end
endmodule

// File: rtl/blackbox_value_checker.sv
// Deserialises a 1-bit stream into WIDTH-bit words and counts bits differing from VALUE.
// Latency: done one cycle after the last sample edge; no backpressure, start ignored while busy.
module blackbox_value_checker
    import blackbox_check_pkg::*;
#(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] VALUE   = WIDTH'(1),
    parameter int unsigned      LATENCY = 0,
    parameter int unsigned      REPEAT  = 1
) (
    input logic                     clock,
    input logic                     reset,
    blackbox_value_checker_if.slave chk
);
    localparam logic [DLY_W-1:0]      DLY_LAST  = DLY_W'(LATENCY - 1);
    localparam logic [WORD_IDX_W-1:0] WORD_LAST = WORD_IDX_W'(REPEAT - 1);

    state_t                state;
    logic [DLY_W-1:0]      dly_cnt;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic                  word_done;
    logic [WIDTH-1:0]      assembled;
    logic                  launch;
    logic                  sampling;
    logic                  exp_bit;
    logic [MISMATCH_W-1:0] mis_next;

    assign launch   = ((state == IDLE) || (state == DONE)) && chk.start;
    assign sampling = (state == SHIFT);

    blackbox_shift_capture #(.WIDTH(WIDTH)) u_capture (
        .clock     (clock),
        .reset     (reset),
        .clear     (launch),
        .sample    (sampling),
        .in        (chk.in),
        .bit_idx   (bit_idx),
        .word_done (word_done),
        .assembled (assembled)
    );

    always_comb begin
        exp_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_idx == BIT_IDX_W'(i)) exp_bit = VALUE[i];
        end
    end

    assign mis_next = ((chk.in != exp_bit) && (chk.mismatches != MISMATCH_SAT))
                    ? chk.mismatches + MISMATCH_W'(1) : chk.mismatches;

    // pass is left alone on launch; it is only meaningful while done is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            dly_cnt        <= '0;
            word_idx       <= '0;
            chk.busy       <= 1'b0;
            chk.done       <= 1'b0;
            chk.pass       <= 1'b0;
            chk.mismatches <= '0;
            chk.word       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (chk.start) begin
                        dly_cnt        <= '0;
                        word_idx       <= '0;
                        chk.mismatches <= '0;
                        chk.word       <= '0;
                        chk.busy       <= 1'b1;
                        chk.done       <= 1'b0;
                        state          <= (LATENCY > 0) ? WAIT : SHIFT;
                    end
                end
                WAIT: begin
                    if (dly_cnt == DLY_LAST) state <= SHIFT;
                    else                     dly_cnt <= dly_cnt + DLY_W'(1);
                end
                SHIFT: begin
                    chk.mismatches <= mis_next;
                    if (word_done) begin
                        chk.word <= assembled;
                        if (word_idx == WORD_LAST) begin
                            state    <= DONE;
                            chk.busy <= 1'b0;
                            chk.done <= 1'b1;
                            chk.pass <= (mis_next == '0);
                        end else begin
                            word_idx <= word_idx + WORD_IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blackbox_value_checker.sv
// Bench for blackbox_value_checker: three configurations, scoreboarded run results
// plus cycle-by-cycle mismatch-count and busy tracking.
module tb_blackbox_value_checker;

    typedef struct {
        logic [63:0] word;
        logic        pass;
        logic [15:0] mis;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        din   = 1'b0;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  pass_v;
    logic [15:0] mis_v  [3];
    logic [63:0] word_v [3];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    blackbox_value_checker_if #(.WIDTH(4)) if_a ();
    blackbox_value_checker_if #(.WIDTH(1)) if_b ();
    blackbox_value_checker_if #(.WIDTH(8)) if_c ();

    blackbox_value_checker #(.WIDTH(4), .VALUE(4'hA), .LATENCY(0), .REPEAT(1)) dut_a (
        .clock(clock), .reset(reset), .chk(if_a));
    blackbox_value_checker #(.WIDTH(1), .VALUE(1'b1), .LATENCY(1), .REPEAT(3)) dut_b (
        .clock(clock), .reset(reset), .chk(if_b));
    blackbox_value_checker #(.WIDTH(8), .VALUE(8'h00), .LATENCY(2), .REPEAT(8300)) dut_c (
        .clock(clock), .reset(reset), .chk(if_c));

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_a.in    = din;
    assign if_b.in    = din;
    assign if_c.in    = din;

    assign busy_v   = {if_c.busy, if_b.busy, if_a.busy};
    assign done_v   = {if_c.done, if_b.done, if_a.done};
    assign pass_v   = {if_c.pass, if_b.pass, if_a.pass};
    assign mis_v[0] = if_a.mismatches;
    assign mis_v[1] = if_b.mismatches;
    assign mis_v[2] = if_c.mismatches;
    assign word_v[0] = 64'(if_a.word);
    assign word_v[1] = 64'(if_b.word);
    assign word_v[2] = 64'(if_c.word);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge; the cycle after acceptance must show busy and no done.
    task automatic launch(input logic [1:0] k);
        start_v[k] = 1'b1;
        @(posedge clock); #1;
        start_v[k] = 1'b0;
        check("launch_busy", 64'(busy_v[k]), 64'd1);
        check("launch_done", 64'(done_v[k]), 64'd0);
    endtask

    // Drives lat ignored cycles then n stream bits (pat repeated every 64 bits).
    task automatic drive(input logic [1:0] k, input int w, input logic [63:0] val,
                         input logic [63:0] pat, input int n, input int lat,
                         input int start_at, input bit word_each, input bit push);
        logic [15:0] mis;
        logic [63:0] wexp;
        mis = 16'd0;
        for (int c = 0; c < lat; c++) begin
            din = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            check("wait_busy", 64'(busy_v[k]), 64'd1);
            check("wait_mismatch", 64'(mis_v[k]), 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            din = pat[6'(i % 64)];
            if (i == start_at) start_v[k] = 1'b1;
            if ((din != val[6'(i % w)]) && (mis != 16'hFFFF)) mis = mis + 16'd1;
            @(posedge clock); #1;
            start_v[k] = 1'b0;
            check("mismatch_count", 64'(mis_v[k]), 64'(mis));
            if (word_each) check("word_each", word_v[k], 64'(din));
            if (i != n - 1) check("run_busy", 64'(busy_v[k]), 64'd1);
        end
        if (push) begin
            wexp = 64'd0;
            for (int j = 0; j < w; j++) wexp[6'(j)] = pat[6'((n - w + j) % 64)];
            sb.push_back('{wexp, (mis == 16'd0), mis});
        end
    endtask

    task automatic collect(input logic [1:0] k, input string tag);
        exp_t e;
        int   waited;
        waited = 0;
        check({tag, "_done_on_time"}, 64'(done_v[k]), 64'd1);
        while (!done_v[k] && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        check({tag, "_busy_low"}, 64'(busy_v[k]), 64'd0);
        check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_word"}, word_v[k], e.word);
            check({tag, "_pass"}, 64'(pass_v[k]), 64'(e.pass));
            check({tag, "_mismatches"}, 64'(mis_v[k]), 64'(e.mis));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no summary, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_done", 64'(done_v[0]), 64'd0);
        check("rst_pass", 64'(pass_v[0]), 64'd0);
        check("rst_mismatches", 64'(mis_v[0]), 64'd0);
        check("rst_word", word_v[0], 64'd0);
        check("rst_done_c", 64'(done_v[2]), 64'd0);
        reset = 1'b0;

        // 0,1,0,1 matches 4'hA; 1,1,0,1 misses bit 0 and, with a mid-run start, must not shift timing.
        launch(0); drive(0, 4, 64'hA, 64'hA, 4, 0, -1, 0, 1); collect(0, "a_match");
        launch(0); drive(0, 4, 64'hA, 64'hB, 4, 0,  1, 0, 1); collect(0, "a_miss");
        launch(0); drive(0, 4, 64'hA, 64'h3, 4, 0, -1, 0, 1); collect(0, "a_relaunch");

        // One-cycle reset mid-run with mismatches and a stale word pending.
        launch(0); drive(0, 4, 64'hA, 64'h5, 2, 0, -1, 0, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_busy", 64'(busy_v[0]), 64'd0);
        check("midrst_done", 64'(done_v[0]), 64'd0);
        check("midrst_pass", 64'(pass_v[0]), 64'd0);
        check("midrst_mismatches", 64'(mis_v[0]), 64'd0);
        check("midrst_word", word_v[0], 64'd0);
        launch(0); drive(0, 4, 64'hA, 64'hA, 4, 0, -1, 0, 1); collect(0, "a_after_reset");

        // WIDTH=1 with one skipped cycle: done four cycles after start.
        launch(1); drive(1, 1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 1, -1, 1, 1); collect(1, "b_latency");
        launch(1); drive(1, 1, 64'h1, 64'h5, 3, 1, -1, 1, 1); collect(1, "b_miss");

        // 66400 mismatching bits saturate the counter.
        launch(2); drive(2, 8, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 66400, 2, -1, 0, 1); collect(2, "c_saturate");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/blackbox_value_checker.md
# blackbox_value_checker

Serial receive-and-check counterpart to the constant/register blackbox drivers used by the Chisel blackbox test suite. Monitors a 1-bit stream `in`, deserialises it LSB-first into WIDTH-bit words and compares each word against the parameter VALUE. Reports done, pass and a saturating mismatch count. Sits on the sink side of a blackbox under test, so a test harness can check a serialised driver output without a Scala-side model.

## Interface
Parameters:
- WIDTH, 1: bits per word; legal range 1..64.
- VALUE, 1: expected word; bit i is compared against the i-th sampled bit of each word.
- LATENCY, 0: cycles skipped after start before the first sample; legal range 0..255. Covers the one-cycle delay of a registered driver.
- REPEAT, 1: number of words checked per run; legal range 1..65535.

Ports (one clock; reset is synchronous and active-high):
- clock, in, 1: sole clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begins a run; sampled only in IDLE or DONE.
- in, in, 1: serial data stream under check.
- busy, out, 1: high in WAIT and SHIFT.
- done, out, 1: high in DONE; held until the next start or reset.
- pass, out, 1: valid when done=1; 1 iff mismatches==0.
- mismatches, out, 16: count of mismatched bits across the run; saturates at 16'hFFFF.
- word, out, WIDTH: last fully captured word.

## Operation
- States:
  - IDLE: reset state.
  - WAIT: waits LATENCY cycles before sampling.
  - SHIFT: samples one bit per cycle.
  - DONE: run complete; results held.
- IDLE or DONE, start=1:
  - Clears mismatches, word, the bit index and the word index.
  - Goes to WAIT if LATENCY>0, otherwise to SHIFT.
- WAIT: the delay counter counts LATENCY cycles, then goes to SHIFT. `in` is ignored.
- SHIFT, each cycle:
  - Sample `in` into a shift register at bit position bit_idx (LSB first).
  - If `in` != VALUE[bit_idx], increment mismatches (saturating).
  - bit_idx wraps at WIDTH-1. On wrap, copy the assembled word to `word` and increment word_idx.
- After the last bit of word REPEAT-1 is sampled: go to DONE and assert done. pass = (mismatches==0), including the final bit's compare.
- start is ignored in WAIT and SHIFT; a run cannot be restarted mid-stream.
- start in DONE behaves exactly as in IDLE: back-to-back runs are allowed.
- Reset at any time, including mid-run: state=IDLE; busy, done, pass, mismatches and word all become 0 on the next edge.
- WIDTH=1: every sample completes a word, and `word` updates every SHIFT cycle.

## Timing
- Reset values: busy=0, done=0, pass=0, mismatches=0, word=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- If start is accepted at edge t:
  - The first sample is the value of `in` at edge t+1+LATENCY.
  - The last sample is at edge t+LATENCY+WIDTH*REPEAT.
  - done=1 is visible in the cycle after that last-sample edge.
- busy=1 from the cycle after edge t until the cycle in which done rises. busy and done are never high together.
- The mismatches update from a sample is visible one cycle after that sample's edge.

## Structure
- Package `blackbox_check_pkg` holds:
  - The state enum (IDLE, WAIT, SHIFT, DONE).
  - MISMATCH_W=16 and the saturation constant.
  - Counter-width helper constants for bit_idx, word_idx and the delay counter.
- Sub-module `blackbox_shift_capture` (WIDTH): an LSB-first shift register with bit index and word-complete strobe. The top level contains the FSM, the compare logic and the counters.

## Test plan
- WIDTH=4, VALUE=4'hA, LATENCY=0, REPEAT=1; drive in = 0,1,0,1 after start → done after 4 sample edges, pass=1, mismatches=0, word=4'hA.
- Same configuration; drive in = 1,1,0,1 → pass=0, mismatches=1, word=4'hB.
- WIDTH=1, VALUE=1, LATENCY=1, REPEAT=3; in is a register-delayed copy of a constant 1 → first sample skipped, pass=1, done rises 4 cycles after start.
- WIDTH=8, VALUE=8'h00, REPEAT=8300; in held at 1 → mismatches saturates at 16'hFFFF, pass=0.
- Assert reset for one cycle mid-SHIFT → next cycle state=IDLE and all outputs 0. A following start runs a clean full check with pass=1.
- Pulse start during SHIFT → ignored, with no timing shift. A second start in DONE relaunches immediately: done drops and busy rises the next cycle.
